// File: rtl/dec_pkg.sv
// Shared constants and types for the decode-stage operand unit: default widths,
// maximal-length Galois LFSR tap masks, and the operand source selector.
package dec_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 5;
  localparam int unsigned DEF_LFSR_W = 16;

  // Right-shifting Galois tap masks; each gives a maximal-length sequence.
  localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // Where a decode operand is taken from, highest priority first.
  typedef enum logic [1:0] {
    FWD_ZERO = 2'd0,
    FWD_M    = 2'd1,
    FWD_W    = 2'd2,
    FWD_RF   = 2'd3
  } fwd_sel_e;

  // Zero means the width has no tap set (rejected at elaboration).
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      8:       return LFSR_TAPS_8;
      16:      return LFSR_TAPS_16;
      32:      return LFSR_TAPS_32;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running right-shift Galois LFSR; advances every clock, loads SEED on reset.
module lfsr_gen
  import dec_pkg::*;
#(
  parameter int unsigned    W    = DEF_LFSR_W,
  parameter logic [W-1:0]   SEED = 1
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] q
);

  localparam logic [31:0]  TAPS_FULL = lfsr_taps(W);
  localparam logic [W-1:0] TAPS      = TAPS_FULL[W-1:0];

  if (TAPS_FULL == 32'h0) begin : g_bad_width
    $error("lfsr_gen: W must be 8, 16 or 32");
  end

  // A zero state is a fixed point of the update, so the seed must be non-zero.
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else begin
      q <= (q >> 1) ^ (q[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/dec_operand_unit.sv
// Decode operand unit: register file with M/W forwarding, long-latency write
// scoreboard driving the decode stall, branch compare flags and an LFSR source.
module dec_operand_unit
  import dec_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned REG_AW    = DEF_REG_AW,
  parameter int unsigned ZERO_REG  = 1,
  parameter int unsigned LFSR_W    = DEF_LFSR_W,
  parameter int unsigned LFSR_SEED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic              rs_used_D,
  input  logic              rt_used_D,
  input  logic              issue_D,
  input  logic              wr_en_D,
  input  logic              long_D,
  input  logic [REG_AW-1:0] dst_D,
  input  logic              wr_M,
  input  logic [REG_AW-1:0] dst_M,
  input  logic [DATA_W-1:0] alu_out_M,
  input  logic              rw,
  input  logic [REG_AW-1:0] write_add,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] src_a_D,
  output logic [DATA_W-1:0] src_b_D,
  output logic              stall_D,
  output logic              a_eq_b_D,
  output logic              a_eq_z_D,
  output logic              a_gt_z_D,
  output logic              a_lt_z_D,
  output logic [LFSR_W-1:0] random_D
);

  localparam int unsigned NREGS = 2 ** REG_AW;
  localparam bit          ZR    = (ZERO_REG != 0);

  if (LFSR_SEED == 0) begin : g_bad_seed
    $error("dec_operand_unit: LFSR_SEED must be non-zero");
  end

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic              wr_commit;
  logic              busy_set;
  fwd_sel_e          sel_a;
  fwd_sel_e          sel_b;
  logic              stall_a;
  logic              stall_b;

  function automatic fwd_sel_e fwd_sel(
    input logic [REG_AW-1:0] r,
    input logic              m_en,
    input logic [REG_AW-1:0] m_dst,
    input logic              w_en,
    input logic [REG_AW-1:0] w_dst
  );
    if (ZR && r == '0)           return FWD_ZERO;
    else if (m_en && m_dst == r) return FWD_M;
    else if (w_en && w_dst == r) return FWD_W;
    else                         return FWD_RF;
  endfunction

  // ---- register file write port ----
  assign wr_commit = rw && !(ZR && write_add == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_commit) begin
      regs[write_add] <= data_in;
    end
  end

  // ---- operand resolution (combinational read + forwarding) ----
  always_comb begin
    sel_a   = fwd_sel(rs_D, wr_M, dst_M, rw, write_add);
    sel_b   = fwd_sel(rt_D, wr_M, dst_M, rw, write_add);
    src_a_D = regs[rs_D];
    src_b_D = regs[rt_D];
    case (sel_a)
      FWD_ZERO: src_a_D = '0;
      FWD_M:    src_a_D = alu_out_M;
      FWD_W:    src_a_D = data_in;
      default:  src_a_D = regs[rs_D];
    endcase
    case (sel_b)
      FWD_ZERO: src_b_D = '0;
      FWD_M:    src_b_D = alu_out_M;
      FWD_W:    src_b_D = data_in;
      default:  src_b_D = regs[rt_D];
    endcase
  end

  // Signed tests against zero reduce to the sign bit and a non-zero check.
  assign a_eq_b_D = (src_a_D == src_b_D);
  assign a_eq_z_D = (src_a_D == '0);
  assign a_lt_z_D = src_a_D[DATA_W-1];
  assign a_gt_z_D = !src_a_D[DATA_W-1] && (src_a_D != '0);

  // ---- scoreboard ----
  assign busy_set = issue_D && wr_en_D && long_D && !(ZR && dst_D == '0);

  // Clear first, then set, so a new long producer wins over the retiring one.
  always_comb begin
    busy_nxt = busy;
    if (rw)       busy_nxt[write_add] = 1'b0;
    if (busy_set) busy_nxt[dst_D]     = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // The retiring write-back satisfies the operand through write-through this cycle.
  assign stall_a = rs_used_D && busy[rs_D] && !(rw && write_add == rs_D);
  assign stall_b = rt_used_D && busy[rt_D] && !(rw && write_add == rt_D);
  assign stall_D = stall_a || stall_b;

  // ---- random source ----
  lfsr_gen #(
    .W    (LFSR_W),
    .SEED (LFSR_W'(LFSR_SEED))
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (random_D)
  );

endmodule

// File: tb/tb_dec_operand_unit.sv
// Bench for dec_operand_unit: directed scenarios plus randomized traffic checked
// against a behavioural register/scoreboard model.
module tb_dec_operand_unit;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;
  localparam int LFSR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [REG_AW-1:0] rs_D, rt_D, dst_D, dst_M, write_add;
  logic              rs_used_D, rt_used_D, issue_D, wr_en_D, long_D, wr_M, rw;
  logic [DATA_W-1:0] alu_out_M, data_in;
  logic [DATA_W-1:0] src_a_D, src_b_D;
  logic              stall_D, a_eq_b_D, a_eq_z_D, a_gt_z_D, a_lt_z_D;
  logic [LFSR_W-1:0] random_D;

  always #5 clk = ~clk;

  dec_operand_unit #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(1), .LFSR_W(LFSR_W), .LFSR_SEED(1)
  ) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .rs_used_D(rs_used_D), .rt_used_D(rt_used_D),
    .issue_D(issue_D), .wr_en_D(wr_en_D), .long_D(long_D), .dst_D(dst_D),
    .wr_M(wr_M), .dst_M(dst_M), .alu_out_M(alu_out_M),
    .rw(rw), .write_add(write_add), .data_in(data_in),
    .src_a_D(src_a_D), .src_b_D(src_b_D), .stall_D(stall_D),
    .a_eq_b_D(a_eq_b_D), .a_eq_z_D(a_eq_z_D), .a_gt_z_D(a_gt_z_D), .a_lt_z_D(a_lt_z_D),
    .random_D(random_D)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [DATA_W-1:0] m_regs [NREGS];
  bit                m_busy [NREGS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Value an instruction should see for register r given this cycle's traffic.
  function automatic logic [DATA_W-1:0] m_read(input logic [REG_AW-1:0] r);
    if (r == 0) return '0;
    if (wr_M && dst_M == r) return alu_out_M;
    if (rw && write_add == r) return data_in;
    return m_regs[r];
  endfunction

  function automatic bit m_waits(input bit used, input logic [REG_AW-1:0] r);
    return used && m_busy[r] && !(rw && write_add == r);
  endfunction

  task automatic check_all(input string tag);
    logic [DATA_W-1:0]        ea, eb;
    logic signed [DATA_W-1:0] sa;
    ea = m_read(rs_D);
    eb = m_read(rt_D);
    sa = ea;
    chk({tag, "_src_a"}, src_a_D, ea);
    chk({tag, "_src_b"}, src_b_D, eb);
    chk({tag, "_stall"}, stall_D, m_waits(rs_used_D, rs_D) || m_waits(rt_used_D, rt_D));
    chk({tag, "_eq_b"}, a_eq_b_D, ea == eb);
    chk({tag, "_eq_z"}, a_eq_z_D, ea == 0);
    chk({tag, "_gt_z"}, a_gt_z_D, sa > 0);
    chk({tag, "_lt_z"}, a_lt_z_D, sa < 0);
  endtask

  // Advance one clock, applying the architectural effect of the inputs held this cycle.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      if (rw) m_busy[write_add] = 1'b0;
      if (rw && write_add != 0) m_regs[write_add] = data_in;
      if (issue_D && wr_en_D && long_D && dst_D != 0) m_busy[dst_D] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rs_D = '0; rt_D = '0; rs_used_D = 0; rt_used_D = 0;
    issue_D = 0; wr_en_D = 0; long_D = 0; dst_D = '0;
    wr_M = 0; dst_M = '0; alu_out_M = '0;
    rw = 0; write_add = '0; data_in = '0;
  endtask

  task automatic issue_long(input logic [REG_AW-1:0] d);
    issue_D = 1; wr_en_D = 1; long_D = 1; dst_D = d;
  endtask

  logic [LFSR_W-1:0] lv [256];
  bit                seen [256];
  int                zeros, dups;
  logic [DATA_W-1:0] pick [6];

  initial begin
    idle();
    model_clear();
    #1 reset = 1'b0;
    #1;
    chk("rst_lfsr", random_D, 8'h01);
    check_all("rst");

    // LFSR: seed first, then the Galois sequence, full period of 255.
    @(negedge clk);
    reset = 1'b1;
    #1 lv[0] = random_D;
    for (int i = 1; i < 256; i++) begin
      @(negedge clk);
      #1 lv[i] = random_D;
    end
    chk("lfsr_v0", lv[0], 8'h01);
    chk("lfsr_v1", lv[1], 8'hB8);
    chk("lfsr_v2", lv[2], 8'h5C);
    zeros = 0; dups = 0;
    for (int i = 0; i < 256; i++) seen[i] = 0;
    for (int i = 0; i < 255; i++) begin
      if (lv[i] == 0) zeros++;
      if (seen[lv[i]]) dups++;
      seen[lv[i]] = 1;
    end
    chk("lfsr_nonzero", zeros, 0);
    chk("lfsr_distinct", dups, 0);
    chk("lfsr_period", lv[255], 8'h01);
    tick();

    // Forwarding priority M > W > array.
    idle(); rw = 1; write_add = 5; data_in = 32'h11;
    #1 check_all("fwd_init");
    tick();
    idle(); rs_D = 5;
    wr_M = 1; dst_M = 5; alu_out_M = 32'h22;
    rw = 1; write_add = 5; data_in = 32'h33;
    #1 chk("fwd_m", src_a_D, 32'h22);
    wr_M = 0;
    #1 chk("fwd_w", src_a_D, 32'h33);
    tick();
    idle(); rs_D = 5;
    #1 chk("fwd_rf", src_a_D, 32'h33);

    // Register 0 ignores writes, forwarding and scoreboard sets.
    idle(); rw = 1; write_add = 0; data_in = 32'hFFFF_FFFF;
    wr_M = 1; dst_M = 0; alu_out_M = 32'h1234;
    issue_long(0);
    #1 chk("zero_fwd", src_a_D, 32'h0);
    chk("zero_eqz", a_eq_z_D, 1'b1);
    tick();
    idle(); rs_used_D = 1;
    #1 chk("zero_stall", stall_D, 1'b0);
    chk("zero_rf", src_a_D, 32'h0);

    // Load-use stall until the write-back of r7.
    idle(); issue_long(7);
    #1 check_all("lu_issue");
    tick();
    idle(); rs_D = 7; rs_used_D = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("lu_stall", stall_D, 1'b1);
      tick();
    end
    rw = 1; write_add = 7; data_in = 32'h55;
    #1 chk("lu_wb_stall", stall_D, 1'b0);
    chk("lu_wb_src_a", src_a_D, 32'h55);
    tick();
    idle(); rs_D = 7; rs_used_D = 1;
    #1 chk("lu_after", stall_D, 1'b0);
    idle(); issue_long(7);
    tick();
    idle(); rs_D = 7;
    for (int i = 0; i < 2; i++) begin
      #1 chk("lu_unused", stall_D, 1'b0);
      tick();
    end
    rt_D = 7; rt_used_D = 1;
    #1 chk("lu_rt_pending", stall_D, 1'b1);
    rw = 1; write_add = 7; data_in = 32'h0;
    tick();

    // Same-cycle clear and set of r9: the set wins.
    idle(); issue_long(9);
    tick();
    idle(); rw = 1; write_add = 9; data_in = 32'h99; issue_long(9);
    #1 check_all("coll");
    tick();
    idle(); rs_D = 9; rs_used_D = 1;
    #1 chk("coll_stall", stall_D, 1'b1);
    rw = 1; write_add = 9; data_in = 32'h9;
    tick();

    // Signed compare flags.
    idle(); rs_D = 1; wr_M = 1; dst_M = 1; alu_out_M = 32'h8000_0000;
    #1 chk("cmp_neg_lt", a_lt_z_D, 1'b1);
    chk("cmp_neg_gt", a_gt_z_D, 1'b0);
    chk("cmp_neg_eqz", a_eq_z_D, 1'b0);
    idle(); rs_D = 4; rt_D = 4; rw = 1; write_add = 4; data_in = 32'h7;
    #1 chk("cmp_eq_b", a_eq_b_D, 1'b1);
    chk("cmp_pos_gt", a_gt_z_D, 1'b1);
    chk("cmp_pos_lt", a_lt_z_D, 1'b0);
    tick();
    idle(); rs_D = 4; rt_D = 5;
    #1 chk("cmp_ne_b", a_eq_b_D, 1'b0);
    check_all("cmp_rf");

    // Randomized traffic with a mid-run reset.
    pick[0] = 32'h0; pick[1] = 32'h7; pick[2] = 32'h8000_0000;
    pick[3] = 32'h7FFF_FFFF; pick[4] = 32'hFFFF_FFFF; pick[5] = 32'h1;
    for (int it = 0; it < 1500; it++) begin
      if (it == 700) begin
        idle(); issue_long(3);
        tick();
        idle();
        reset = 1'b0;
        model_clear();
        for (int r = 0; r < 12; r++) begin
          rs_D = REG_AW'(r); rt_D = REG_AW'(r); rs_used_D = 1; rt_used_D = 1;
          #1 chk("mrst_stall", stall_D, 1'b0);
          chk("mrst_src_a", src_a_D, 32'h0);
          chk("mrst_lfsr", random_D, 8'h01);
          tick();
        end
        reset = 1'b1;
      end
      rs_D      = REG_AW'($urandom_range(0, 11));
      rt_D      = REG_AW'($urandom_range(0, 11));
      rs_used_D = 1'($urandom_range(0, 1));
      rt_used_D = 1'($urandom_range(0, 1));
      issue_D   = ($urandom_range(0, 2) == 0);
      wr_en_D   = 1'($urandom_range(0, 1));
      long_D    = 1'($urandom_range(0, 1));
      dst_D     = REG_AW'($urandom_range(0, 11));
      wr_M      = ($urandom_range(0, 3) == 0);
      dst_M     = REG_AW'($urandom_range(0, 11));
      alu_out_M = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      rw        = 1'($urandom_range(0, 1));
      write_add = REG_AW'($urandom_range(0, 11));
      data_in   = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      #1 check_all("rnd");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
